i_fetch_ctrl: RTL and testbench

I_FETCH_CTRL -- requirements
Module: i_fetch_ctrl

---
 rtl/i_fetch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_i_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// i_fetch_ctrl
//
// Instruction fetch controller. A program counter addresses an async-read
// instruction ROM; each fetched word is pushed together with its address
// into a 2-entry FIFO whose head is presented to decode. Redirects flush the
// FIFO and reload the pc; halt stops fetching while queued entries drain.
//
// Optional feature (macro PJ_FETCH_STALL_CNT_EN): adds stall_cnt_o, a
// saturating count of RUN cycles in which decode back-pressures a valid
// instruction.
//
// Handshake: an instruction transfers to decode on a cycle where
// instr_v_o && instr_ready_i at the rising edge; instr_o/instr_pc_o are held
// stable while instr_v_o is high and instr_ready_i is low.
//
// Ports:
//   clk_i          in   clock, rising edge
//   reset_n_i      in   synchronous active-low reset
//   start_i        in   leave IDLE/HALT and (re)start fetching
//   halt_i         in   stop fetching (RUN only)
//   rom_addr_o     out  ROM address (current pc)
//   rom_data_i     in   ROM word at rom_addr_o, same cycle
//   redirect_v_i   in   redirect strobe (RUN/HALT only)
//   redirect_pc_i  in   redirect target
//   instr_v_o      out  instruction valid to decode
//   instr_o        out  instruction word (FIFO head)
//   instr_pc_o     out  address of instr_o
//   instr_ready_i  in   decode accepts
//   halted_o       out  high while in HALT
//   state_o        out  debug view of the FSM state (0 IDLE, 1 RUN, 2 HALT)
//   stall_cnt_o    out  16-bit stall counter (only with PJ_FETCH_STALL_CNT_EN)
// ---------------------------------------------------------------------------
module i_fetch_ctrl #(
    parameter int I_ROM_DEPTH_P = 16,
    parameter int WORD_SIZE_P   = 32,
    parameter int RESET_PC_P    = 0,
    localparam int ADDR_WIDTH_LP = $clog2(I_ROM_DEPTH_P)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     start_i,
    input  logic                     halt_i,
    output logic [ADDR_WIDTH_LP-1:0] rom_addr_o,
    input  logic [WORD_SIZE_P-1:0]   rom_data_i,
    input  logic                     redirect_v_i,
    input  logic [ADDR_WIDTH_LP-1:0] redirect_pc_i,
    output logic                     instr_v_o,
    output logic [WORD_SIZE_P-1:0]   instr_o,
    output logic [ADDR_WIDTH_LP-1:0] instr_pc_o,
    input  logic                     instr_ready_i,
    output logic                     halted_o,
    output logic [1:0]               state_o
`ifdef PJ_FETCH_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [ADDR_WIDTH_LP-1:0] RESET_PC_LP = ADDR_WIDTH_LP'(RESET_PC_P);
    localparam logic [ADDR_WIDTH_LP-1:0] LAST_PC_LP  = ADDR_WIDTH_LP'(I_ROM_DEPTH_P - 1);

    logic [1:0]               state_q, state_d;
    logic [ADDR_WIDTH_LP-1:0] pc_q, pc_d, pc_inc;
    logic [1:0]               count_q, count_d;
    logic [1:0]               wr_slot;

    // FIFO storage: entry 0 is always the head.
    logic [WORD_SIZE_P-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic [ADDR_WIDTH_LP-1:0] epc0_q, epc0_d, epc1_q, epc1_d;

    logic redirect_act;
    logic deq;
    logic enq;

    // A redirect strobe always masks instr_v_o, even in IDLE where the FIFO
    // is empty anyway; it only takes effect outside IDLE.
    assign redirect_act = redirect_v_i && (state_q != ST_IDLE);
    assign instr_v_o    = (count_q != 2'd0) && !redirect_v_i;
    assign deq          = instr_v_o && instr_ready_i;
    assign enq          = (state_q == ST_RUN) && ((count_q != 2'd2) || deq)
                          && !halt_i && !redirect_v_i;

    // Explicit wrap so non-power-of-two ROM depths work.
    assign pc_inc  = (pc_q == LAST_PC_LP) ? '0 : pc_q + 1'b1;
    // After a same-cycle dequeue the tail slot moves down by one.
    assign wr_slot = count_q - {1'b0, deq};

    assign rom_addr_o = pc_q;
    assign instr_o    = data0_q;
    assign instr_pc_o = epc0_q;
    assign halted_o   = (state_q == ST_HALT);
    assign state_o    = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (halt_i)  state_d = ST_HALT;
            ST_HALT: if (start_i) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        data0_d = data0_q;
        data1_d = data1_q;
        epc0_d  = epc0_q;
        epc1_d  = epc1_q;
        if (redirect_act) begin
            count_d = 2'd0;
            pc_d    = redirect_pc_i;
        end else begin
            if (deq) begin
                data0_d = data1_q;
                epc0_d  = epc1_q;
            end
            if (enq) begin
                if (wr_slot == 2'd0) begin
                    data0_d = rom_data_i;
                    epc0_d  = pc_q;
                end else begin
                    data1_d = rom_data_i;
                    epc1_d  = pc_q;
                end
                pc_d = pc_inc;
            end
            count_d = count_q + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC_LP;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Payload registers need no reset: they are only observed when count != 0.
    always_ff @(posedge clk_i) begin
        data0_q <= data0_d;
        data1_q <= data1_d;
        epc0_q  <= epc0_d;
        epc1_q  <= epc1_d;
    end

`ifdef PJ_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic        stall_inc;

    assign stall_inc   = (state_q == ST_RUN) && instr_v_o && !instr_ready_i
                         && (stall_cnt_q != 16'hFFFF);
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stall_cnt_q <= 16'd0;
        end else if (stall_inc) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
`else
    // Stall counter not built.
`endif

endmodule

// File: tb/tb_i_fetch_ctrl.sv
module tb_i_fetch_ctrl;

    // DUT A: non-power-of-two depth, 4-bit addresses. DUT B: depth 5 for wrap.
    localparam int DEPTH_A = 12;
    localparam int DEPTH_B = 5;
    localparam int WORD    = 16;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        halt;
    logic        ready;
    logic        a_redirect_v;
    logic [3:0]  a_redirect_pc;
    logic        b_redirect_v;
    logic [2:0]  b_redirect_pc;

    logic [3:0]  a_rom_addr;
    logic [15:0] a_rom_data;
    logic        a_instr_v;
    logic [15:0] a_instr;
    logic [3:0]  a_instr_pc;
    logic        a_halted;
    logic [1:0]  a_state;

    logic [2:0]  b_rom_addr;
    logic [15:0] b_rom_data;
    logic        b_instr_v;
    logic [15:0] b_instr;
    logic [2:0]  b_instr_pc;
    logic        b_halted;
    logic [1:0]  b_state;

`ifdef PJ_FETCH_STALL_CNT_EN
    logic [15:0] a_stall_cnt;
    logic [15:0] b_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // ROM contents: a distinct word per address.
    function automatic logic [15:0] rom_word(input logic [3:0] a);
        return {4'hB, a, ~a, a ^ 4'h5};
    endfunction

    assign a_rom_data = rom_word(a_rom_addr);
    assign b_rom_data = rom_word({1'b0, b_rom_addr});

    i_fetch_ctrl #(
        .I_ROM_DEPTH_P(DEPTH_A),
        .WORD_SIZE_P  (WORD),
        .RESET_PC_P   (0)
    ) u_dut_a (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .start_i      (start),
        .halt_i       (halt),
        .rom_addr_o   (a_rom_addr),
        .rom_data_i   (a_rom_data),
        .redirect_v_i (a_redirect_v),
        .redirect_pc_i(a_redirect_pc),
        .instr_v_o    (a_instr_v),
        .instr_o      (a_instr),
        .instr_pc_o   (a_instr_pc),
        .instr_ready_i(ready),
        .halted_o     (a_halted),
        .state_o      (a_state)
`ifdef PJ_FETCH_STALL_CNT_EN
        ,
        .stall_cnt_o  (a_stall_cnt)
`endif
    );

    i_fetch_ctrl #(
        .I_ROM_DEPTH_P(DEPTH_B),
        .WORD_SIZE_P  (WORD),
        .RESET_PC_P   (0)
    ) u_dut_b (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .start_i      (start),
        .halt_i       (halt),
        .rom_addr_o   (b_rom_addr),
        .rom_data_i   (b_rom_data),
        .redirect_v_i (b_redirect_v),
        .redirect_pc_i(b_redirect_pc),
        .instr_v_o    (b_instr_v),
        .instr_o      (b_instr),
        .instr_pc_o   (b_instr_pc),
        .instr_ready_i(ready),
        .halted_o     (b_halted),
        .state_o      (b_state)
`ifdef PJ_FETCH_STALL_CNT_EN
        ,
        .stall_cnt_o  (b_stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- vector table ----------------
    // Each row: inputs driven for one cycle, and the outputs expected in that
    // same cycle (before the next rising edge).
    typedef struct {
        logic        rn;
        logic        st;
        logic        ha;
        logic        rd;
        logic        rv;
        logic [3:0]  rpc;
        logic        ev;
        logic [3:0]  epc;
        logic [3:0]  eaddr;
        logic        eh;
        logic [1:0]  est;
        logic [15:0] estall;
    } vec_t;

    localparam int N_VEC = 36;
    vec_t vecs[N_VEC];

    function automatic vec_t mk(input int rn, input int st, input int ha, input int rd,
                                input int rv, input int rpc, input int ev, input int epc,
                                input int eaddr, input int eh, input int est, input int estall);
        vec_t v;
        v.rn     = rn[0];
        v.st     = st[0];
        v.ha     = ha[0];
        v.rd     = rd[0];
        v.rv     = rv[0];
        v.rpc    = rpc[3:0];
        v.ev     = ev[0];
        v.epc    = epc[3:0];
        v.eaddr  = eaddr[3:0];
        v.eh     = eh[0];
        v.est    = est[1:0];
        v.estall = estall[15:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic st, input logic ha, input logic rd,
                         input logic rv, input logic [3:0] rpc);
        reset_n       = rn;
        start         = st;
        halt          = ha;
        ready         = rd;
        a_redirect_v  = rv;
        a_redirect_pc = rpc;
    endtask

    initial begin
        //           rn st ha rd rv rpc | ev epc addr h st stall
        vecs[0]  = mk(1, 1, 0, 1, 0, 0,   0, 0,  0, 0, 0, 0); // start sampled
        vecs[1]  = mk(1, 0, 0, 1, 0, 0,   0, 0,  0, 0, 1, 0); // RUN, FIFO empty
        vecs[2]  = mk(1, 0, 0, 1, 0, 0,   1, 0,  1, 0, 1, 0); // first valid pc 0
        vecs[3]  = mk(1, 0, 0, 1, 0, 0,   1, 1,  2, 0, 1, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0,   1, 2,  3, 0, 1, 0); // stall 1
        vecs[5]  = mk(1, 0, 0, 0, 0, 0,   1, 2,  4, 0, 1, 1); // full, pc holds
        vecs[6]  = mk(1, 0, 0, 0, 0, 0,   1, 2,  4, 0, 1, 2);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0,   1, 2,  4, 0, 1, 3);
        vecs[8]  = mk(1, 0, 0, 1, 0, 0,   1, 2,  4, 0, 1, 4); // release: deq+enq
        vecs[9]  = mk(1, 0, 0, 1, 0, 0,   1, 3,  5, 0, 1, 4);
        vecs[10] = mk(1, 0, 0, 0, 0, 0,   1, 4,  6, 0, 1, 4); // full again
        vecs[11] = mk(1, 0, 0, 1, 1, 9,   0, 0,  6, 0, 1, 5); // redirect to 9
        vecs[12] = mk(1, 0, 0, 1, 0, 0,   0, 0,  9, 0, 1, 5);
        vecs[13] = mk(1, 0, 0, 1, 0, 0,   1, 9, 10, 0, 1, 5);
        vecs[14] = mk(1, 0, 0, 1, 0, 0,   1, 10, 11, 0, 1, 5);
        vecs[15] = mk(1, 0, 0, 1, 0, 0,   1, 11, 0, 0, 1, 5); // pc wrapped 11->0
        vecs[16] = mk(1, 0, 0, 0, 0, 0,   1, 0,  1, 0, 1, 5);
        vecs[17] = mk(1, 0, 1, 0, 0, 0,   1, 0,  2, 0, 1, 6); // halt with 2 queued
        vecs[18] = mk(1, 0, 0, 1, 0, 0,   1, 0,  2, 1, 2, 7); // drain
        vecs[19] = mk(1, 0, 0, 1, 0, 0,   1, 1,  2, 1, 2, 7);
        vecs[20] = mk(1, 0, 0, 1, 0, 0,   0, 0,  2, 1, 2, 7); // drained
        vecs[21] = mk(1, 1, 0, 1, 0, 0,   0, 0,  2, 1, 2, 7); // resume
        vecs[22] = mk(1, 0, 0, 1, 0, 0,   0, 0,  2, 0, 1, 7);
        vecs[23] = mk(1, 0, 0, 1, 0, 0,   1, 2,  3, 0, 1, 7); // resumed at held pc
        vecs[24] = mk(1, 0, 1, 0, 1, 5,   0, 0,  4, 0, 1, 7); // redirect + halt
        vecs[25] = mk(1, 0, 0, 1, 0, 0,   0, 0,  5, 1, 2, 7);
        vecs[26] = mk(1, 1, 0, 1, 1, 7,   0, 0,  5, 1, 2, 7); // start + redirect
        vecs[27] = mk(1, 0, 0, 1, 0, 0,   0, 0,  7, 0, 1, 7);
        vecs[28] = mk(1, 0, 0, 1, 0, 0,   1, 7,  8, 0, 1, 7);
        vecs[29] = mk(1, 0, 0, 0, 0, 0,   1, 8,  9, 0, 1, 7);
        vecs[30] = mk(1, 0, 0, 0, 0, 0,   1, 8, 10, 0, 1, 8); // full
        vecs[31] = mk(0, 0, 0, 1, 0, 0,   1, 8, 10, 0, 1, 9); // reset mid-stream
        vecs[32] = mk(1, 0, 0, 1, 0, 0,   0, 0,  0, 0, 0, 0);
        vecs[33] = mk(1, 0, 0, 1, 1, 3,   0, 0,  0, 0, 0, 0); // redirect ignored in IDLE
        vecs[34] = mk(1, 0, 1, 1, 0, 0,   0, 0,  0, 0, 0, 0); // halt ignored in IDLE
        vecs[35] = mk(1, 0, 0, 1, 0, 0,   0, 0,  0, 0, 0, 0);

        b_redirect_v  = 1'b0;
        b_redirect_pc = 3'd0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check("reset instr_v",  32'(a_instr_v),  32'd0);
        check("reset halted",   32'(a_halted),   32'd0);
        check("reset rom_addr", 32'(a_rom_addr), 32'd0);
        check("reset state",    32'(a_state),    32'd0);

        // ---------------- table ----------------
        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk);
            drive(vecs[i].rn, vecs[i].st, vecs[i].ha, vecs[i].rd, vecs[i].rv, vecs[i].rpc);
            #1;
            check($sformatf("row%0d instr_v", i),  32'(a_instr_v),  32'(vecs[i].ev));
            check($sformatf("row%0d rom_addr", i), 32'(a_rom_addr), 32'(vecs[i].eaddr));
            check($sformatf("row%0d halted", i),   32'(a_halted),   32'(vecs[i].eh));
            check($sformatf("row%0d state", i),    32'(a_state),    32'(vecs[i].est));
            if (vecs[i].ev) begin
                check($sformatf("row%0d instr_pc", i), 32'(a_instr_pc), 32'(vecs[i].epc));
                check($sformatf("row%0d instr", i),    32'(a_instr),    32'(rom_word(vecs[i].epc)));
            end
`ifdef PJ_FETCH_STALL_CNT_EN
            check($sformatf("row%0d stall_cnt", i), 32'(a_stall_cnt), 32'(vecs[i].estall));
`endif
        end

        // ---------------- start pulse, streaming on both DUTs ----------------
        // Cycle k=0 samples start; first valid appears at k=2 with pc 0.
        // DUT B (depth 5) must wrap: 0,1,2,3,4,0,1.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        #1;
        check("stream k0 b_instr_v", 32'(b_instr_v), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            #1;
            if (k == 1) begin
                check("stream k1 a_instr_v", 32'(a_instr_v), 32'd0);
                check("stream k1 b_instr_v", 32'(b_instr_v), 32'd0);
                check("stream k1 b_state",   32'(b_state),   32'd1);
            end else begin
                check($sformatf("stream k%0d a_instr_v", k), 32'(a_instr_v), 32'd1);
                check($sformatf("stream k%0d a_instr_pc", k), 32'(a_instr_pc), 32'(k - 2));
                check($sformatf("stream k%0d a_instr", k), 32'(a_instr),
                      32'(rom_word(4'(k - 2))));
                check($sformatf("stream k%0d b_instr_v", k), 32'(b_instr_v), 32'd1);
                check($sformatf("stream k%0d b_instr_pc", k), 32'(b_instr_pc), 32'((k - 2) % 5));
                check($sformatf("stream k%0d b_instr", k), 32'(b_instr),
                      32'(rom_word(4'((k - 2) % 5))));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
